// File: rtl/middle_ram_reader_if.sv
// Burst-read bus between middle_ram_reader and its RAM / stream sink.
// o_last exists only when MIDDLE_RAM_READER_LAST_EN is defined.
interface middle_ram_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_ready;
    logic              busy;
    logic              done;
`ifdef MIDDLE_RAM_READER_LAST_EN
    logic              o_last;
`endif

    // Stream handshake: a word moves when o_valid && o_ready at a rising edge;
    // once o_valid is high, o_data holds until that transfer happens.
    modport master (
        input  start, base_addr, length, q, o_ready,
        output rdaddress, o_data, o_valid, busy, done
`ifdef MIDDLE_RAM_READER_LAST_EN
        , output o_last
`endif
    );

    modport slave (
        output start, base_addr, length, q, o_ready,
        input  rdaddress, o_data, o_valid, busy, done
`ifdef MIDDLE_RAM_READER_LAST_EN
        , input o_last
`endif
    );
endinterface

// File: rtl/middle_ram_reader.sv
// Burst reader: streams length words from a 1-cycle-latency RAM through a 2-entry FIFO.
// Optional o_last flag on the final word is enabled by MIDDLE_RAM_READER_LAST_EN.
module middle_ram_reader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    middle_ram_reader_if.master  bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_rdaddress;
    logic [ADDR_W:0]   r_to_issue;
    logic [ADDR_W:0]   r_left;
    logic              r_primed;
    logic              r_inflight;
    logic              r_wptr;
    logic              r_rptr;
    logic              r_done;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_fifo [2];

    logic              w_start_go;
    logic              w_start_zero;
    logic              w_xfer;
    logic              w_issue;
    logic              w_done_set;
    logic              w_last_word;
    logic [1:0]        w_occ;

    assign w_xfer       = (r_count != 2'd0) && bus.o_ready;
    assign w_occ        = r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
    assign w_start_go   = (r_state == S_IDLE) && bus.start && (bus.length != '0);
    assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.length == '0);
    assign w_last_word  = (r_left == (ADDR_W + 1)'(1));
    // The first READ cycle only sets up rdaddress, so the first word lands
    // three edges after start while issue-to-FIFO stays two edges deep.
    assign w_issue      = (r_state == S_READ) && r_primed && (w_occ < 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_go) w_next_state = S_READ;
            S_READ:  if (w_issue && (r_to_issue == (ADDR_W + 1)'(1))) w_next_state = S_DRAIN;
            S_DRAIN: if (w_xfer && w_last_word) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_done_set    = w_start_zero || ((r_state == S_DRAIN) && w_xfer && w_last_word);
        bus.busy      = (r_state != S_IDLE);
        bus.done      = r_done;
        bus.rdaddress = r_rdaddress;
        bus.o_valid   = (r_count != 2'd0);
        bus.o_data    = r_fifo[r_rptr];
`ifdef MIDDLE_RAM_READER_LAST_EN
        bus.o_last    = (r_count != 2'd0) && w_last_word;
`endif
        o_dbg_state   = r_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdaddress <= '0;
            r_to_issue  <= '0;
            r_left      <= '0;
            r_primed    <= 1'b0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_done      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_done     <= w_done_set;
            r_inflight <= w_issue;
            r_primed   <= (r_state == S_READ);
            r_count    <= w_occ;
            if (w_start_go) begin
                r_rdaddress <= bus.base_addr;
                r_to_issue  <= bus.length;
                r_left      <= bus.length;
            end
            if (w_issue) begin
                r_rdaddress <= r_rdaddress + 1'b1;
                r_to_issue  <= r_to_issue - 1'b1;
            end
            // q belongs to the read issued last cycle; it is captured even under backpressure.
            if (r_inflight) begin
                r_fifo[r_wptr] <= bus.q;
                r_wptr         <= ~r_wptr;
            end
            if (w_xfer) begin
                r_rptr <= ~r_rptr;
                r_left <= r_left - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_middle_ram_reader.sv
// Directed bench for middle_ram_reader against a 1-cycle RAM holding data[a] = a[7:0].
module tb_middle_ram_reader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clock = ~clock;

  middle_ram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  middle_ram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always @(posedge clock) bus.q <= bus.rdaddress[7:0];

  // driver: raise start for one edge; returns at the negedge after the sampling edge
  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.length = l;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.o_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.rdaddress !== 14'd0) begin failures++; $display("FAIL reset_rdaddress got=%0d exp=0", bus.rdaddress); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%0b exp=0", bus.o_valid); end
    checks++; if (bus.o_data !== 8'h00) begin failures++; $display("FAIL reset_o_data got=%0h exp=0", bus.o_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
`ifdef MIDDLE_RAM_READER_LAST_EN
    checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL reset_o_last got=%0b exp=0", bus.o_last); end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_burst;
    bus.o_ready = 1'b1;
    pulse_start(14'd0, 15'd50);
    for (int k = 0; k < 56; k++) begin
      logic ev;
      ev = (k >= 3) && (k <= 52);
      checks++; if (bus.o_valid !== ev) begin failures++; $display("FAIL basic_valid k=%0d got=%0b exp=%0b", k, bus.o_valid, ev); end
      if (ev) begin
        checks++; if (bus.o_data !== 8'(k - 3)) begin failures++; $display("FAIL basic_data k=%0d got=%0h exp=%0h", k, bus.o_data, 8'(k - 3)); end
      end
      checks++; if (bus.done !== (k == 53)) begin failures++; $display("FAIL basic_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 53)); end
      checks++; if (bus.busy !== (k <= 52)) begin failures++; $display("FAIL basic_busy k=%0d got=%0b exp=%0b", k, bus.busy, (k <= 52)); end
`ifdef MIDDLE_RAM_READER_LAST_EN
      checks++; if (bus.o_last !== (k == 52)) begin failures++; $display("FAIL basic_last k=%0d got=%0b exp=%0b", k, bus.o_last, (k == 52)); end
`endif
      @(negedge clock);
    end
  endtask

  task automatic test_wrap;
    logic [ADDR_W-1:0] exp_addr[4];
    logic [DATA_W-1:0] exp_data[4];
    exp_addr = '{14'd16382, 14'd16383, 14'd0, 14'd1};
    exp_data = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bus.o_ready = 1'b1;
    pulse_start(14'd16382, 15'd4);
    for (int k = 0; k < 9; k++) begin
      if (k >= 1 && k <= 4) begin
        checks++; if (bus.rdaddress !== exp_addr[k-1]) begin failures++; $display("FAIL wrap_rdaddress k=%0d got=%0d exp=%0d", k, bus.rdaddress, exp_addr[k-1]); end
      end
      checks++; if (bus.o_valid !== (k >= 3 && k <= 6)) begin failures++; $display("FAIL wrap_valid k=%0d got=%0b", k, bus.o_valid); end
      if (k >= 3 && k <= 6) begin
        checks++; if (bus.o_data !== exp_data[k-3]) begin failures++; $display("FAIL wrap_data k=%0d got=%0h exp=%0h", k, bus.o_data, exp_data[k-3]); end
      end
      checks++; if (bus.done !== (k == 7)) begin failures++; $display("FAIL wrap_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 7)); end
      @(negedge clock);
    end
  endtask

  task automatic test_stall;
    int  cyc;
    bit  done_seen;
    bit  stalled;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h20 + i));
    done_seen = 1'b0;
    stalled = 1'b0;
    bus.o_ready = 1'b1;
    pulse_start(14'h20, 15'd10);
    for (cyc = 0; cyc < 80 && !done_seen; cyc++) begin
      bus.o_ready = (cyc % 3 == 0);
      if (stalled) begin
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid cyc=%0d got=%0b exp=1", cyc, bus.o_valid); end
      end
      if (bus.o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL stall_extra_word cyc=%0d got=%0h exp=none", cyc, bus.o_data);
        end else begin
          checks++; if (bus.o_data !== exp_q[0]) begin failures++; $display("FAIL stall_data cyc=%0d got=%0h exp=%0h", cyc, bus.o_data, exp_q[0]); end
          if (bus.o_ready) void'(exp_q.pop_front());
        end
      end
      stalled = (bus.o_valid === 1'b1) && !bus.o_ready;
      if (bus.done === 1'b1) begin
        done_seen = 1'b1;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_done_early left=%0d exp=0", exp_q.size()); end
      end
      @(negedge clock);
    end
    checks++; if (!done_seen) begin failures++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_missing got=%0d_left exp=0", exp_q.size()); end
    bus.o_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_len_zero;
    bus.o_ready = 1'b1;
    pulse_start(14'h10, 15'd0);
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.done !== (k == 0)) begin failures++; $display("FAIL zero_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 0)); end
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL zero_valid k=%0d got=%0b exp=0", k, bus.o_valid); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_busy k=%0d got=%0b exp=0", k, bus.busy); end
      @(negedge clock);
    end
  endtask

  task automatic test_start_while_busy;
    bus.o_ready = 1'b1;
    pulse_start(14'd0, 15'd5);
    for (int k = 0; k < 13; k++) begin
      if (k == 4) begin bus.start = 1'b1; bus.base_addr = 14'd200; bus.length = 15'd7; end
      if (k == 5) bus.start = 1'b0;
      checks++; if (bus.o_valid !== (k >= 3 && k <= 7)) begin failures++; $display("FAIL busy_start_valid k=%0d got=%0b", k, bus.o_valid); end
      if (k >= 3 && k <= 7) begin
        checks++; if (bus.o_data !== 8'(k - 3)) begin failures++; $display("FAIL busy_start_data k=%0d got=%0h exp=%0h", k, bus.o_data, 8'(k - 3)); end
      end
      checks++; if (bus.done !== (k == 8)) begin failures++; $display("FAIL busy_start_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 8)); end
      checks++; if (bus.busy !== (k <= 7)) begin failures++; $display("FAIL busy_start_busy k=%0d got=%0b exp=%0b", k, bus.busy, (k <= 7)); end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_burst;
    bus.o_ready = 1'b1;
    pulse_start(14'd0, 15'd20);
    repeat (8) @(negedge clock);
    checks++; if (bus.o_data !== 8'h05) begin failures++; $display("FAIL midrst_before got=%0h exp=05", bus.o_data); end
    reset = 1'b1;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", bus.o_valid); end
    checks++; if (bus.o_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%0h exp=0", bus.o_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.rdaddress !== 14'd0) begin failures++; $display("FAIL midrst_rdaddress got=%0d exp=0", bus.rdaddress); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done k=%0d got=%0b exp=0", k, bus.done); end
    end
    reset = 1'b0;
    @(negedge clock);
    pulse_start(14'd100, 15'd3);
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.o_valid !== (k >= 3 && k <= 5)) begin failures++; $display("FAIL restart_valid k=%0d got=%0b", k, bus.o_valid); end
      if (k >= 3 && k <= 5) begin
        checks++; if (bus.o_data !== 8'(8'h64 + k - 3)) begin failures++; $display("FAIL restart_data k=%0d got=%0h exp=%0h", k, bus.o_data, 8'(8'h64 + k - 3)); end
      end
      checks++; if (bus.done !== (k == 6)) begin failures++; $display("FAIL restart_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 6)); end
`ifdef MIDDLE_RAM_READER_LAST_EN
      checks++; if (bus.o_last !== (k == 5)) begin failures++; $display("FAIL restart_last k=%0d got=%0b exp=%0b", k, bus.o_last, (k == 5)); end
`endif
      @(negedge clock);
    end
  endtask

  task automatic test_single_word;
    bus.o_ready = 1'b1;
    pulse_start(14'h33, 15'd1);
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.o_valid !== (k == 3)) begin failures++; $display("FAIL single_valid k=%0d got=%0b exp=%0b", k, bus.o_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (bus.o_data !== 8'h33) begin failures++; $display("FAIL single_data got=%0h exp=33", bus.o_data); end
      end
      checks++; if (bus.done !== (k == 4)) begin failures++; $display("FAIL single_done k=%0d got=%0b exp=%0b", k, bus.done, (k == 4)); end
`ifdef MIDDLE_RAM_READER_LAST_EN
      checks++; if (bus.o_last !== (k == 3)) begin failures++; $display("FAIL single_last k=%0d got=%0b exp=%0b", k, bus.o_last, (k == 3)); end
`endif
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_wrap();
    test_stall();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_burst();
    test_single_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/middle_ram_reader.md
MIDDLE_RAM_READER -- requirements
Module: middle_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the RAM address width (16384 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the pixel/RAM word width.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset; it is asynchronous and active-high.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr  input  ADDR_W  meaning the first RAM address of the burst, sampled with start.
REQ-007 SHALL have port length  input  ADDR_W+1  meaning the word count (0..16384), sampled with start.
REQ-008 SHALL have port rdaddress  output  ADDR_W  meaning the RAM read address (RAM q follows with 1-cycle latency).
REQ-009 SHALL have port q  input  DATA_W  meaning the RAM read data.
REQ-010 SHALL have port o_data  output  DATA_W  meaning the stream data.
REQ-011 SHALL have port o_valid  output  1  meaning o_data is valid.
REQ-012 SHALL have port o_ready  input  1  meaning the sink accepts; a transfer occurs when o_valid and o_ready are both high at a rising edge.
REQ-013 SHALL have port busy  output  1  meaning a burst is in progress (state not IDLE).
REQ-014 SHALL have port done  output  1  meaning a one-cycle pulse after the last word of a burst has transferred.

Function
REQ-015 SHALL implement states IDLE, READ and DRAIN.
REQ-016 IDLE -> READ when start is high and length != 0; base_addr and length are latched on that edge.
REQ-017 start with length == 0 SHALL stay in IDLE, emit no data and pulse done on the following cycle.
REQ-018 start while busy SHALL be ignored.
REQ-019 SHALL hold a 2-entry output FIFO plus an in-flight flag for the read issued on the previous cycle.
REQ-020 In READ, a read SHALL be issued (rdaddress advanced and in-flight set) only when FIFO occupancy + in-flight - (transfer this cycle) < 2, so the FIFO never overflows.
REQ-021 Issued addresses SHALL be base_addr, base_addr+1, ... modulo 2^ADDR_W (16383 wraps to 0).
REQ-022 q SHALL be written into the FIFO on the cycle after the corresponding issue, regardless of o_ready.
REQ-023 READ -> DRAIN when length reads have been issued; DRAIN -> IDLE when the FIFO is empty, in-flight is clear and the final transfer has occurred, with done high for exactly that one following cycle.
REQ-024 The first o_valid SHALL be asserted on the third rising edge after the edge that samples start; with o_ready held high, throughput SHALL be one word per cycle.
REQ-025 o_data/o_valid SHALL remain stable while o_valid is high and o_ready is low.
REQ-026 Words SHALL be delivered in address order, none dropped or duplicated.

Reset
REQ-027 Reset SHALL force state IDLE, FIFO empty, in-flight clear, rdaddress=0, o_valid=0, o_data=0, busy=0, done=0, o_last=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst without a done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-029 With macro MIDDLE_RAM_READER_LAST_EN defined, output port o_last (1 bit) SHALL exist and be high together with o_valid on the final word of a burst only.
REQ-030 Without MIDDLE_RAM_READER_LAST_EN, o_last SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-031 RAM preloaded data[a]=a[7:0]; start, base_addr=0, length=50, o_ready=1 -> o_data 0x00..0x31 on 50 consecutive cycles, first o_valid 3 edges after start, done one cycle after the last transfer.
REQ-032 base_addr=16382, length=4 -> rdaddress sequence 16382, 16383, 0, 1; o_data 0xFE, 0xFF, 0x00, 0x01.
REQ-033 length=10 with o_ready toggling 1,0,0,1,... -> all 10 words in order, o_data stable while stalled, occupancy never above 2.
REQ-034 length=0 -> no o_valid, done pulses once the cycle after start; a start during an active burst -> no effect on that burst.
REQ-035 Reset asserted after 5 of 20 words -> all outputs at reset values immediately, no done pulse; a new start with base_addr=100, length=3 -> 0x64, 0x65, 0x66.
REQ-036 With MIDDLE_RAM_READER_LAST_EN defined, length=3 -> o_last high only with the third word; a length=1 burst -> o_last high on its single word.
